// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types, defaults and width helper for the matrix multiply engine
//   Contents: DATA_W/ADDR_W defaults, engine state encoding, accumulator width function.
package matmul_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 6;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_MAC   = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // Wide enough that INNER full-scale products can never wrap the sum.
    function automatic int acc_width(input int data_w, input int inner);
        return 2 * data_w + $clog2(inner);
    endfunction

endpackage

// File: rtl/matmul_engine_mac_sat.sv
// rtl/matmul_engine_mac_sat.sv - multiply-accumulate register with saturating readout
//   clk, rst          : clock, asynchronous active-high reset
//   clr               : zero the accumulator (wins over acc_en)
//   acc_en            : add a*b into the accumulator
//   a, b              : operand bytes from the A and B memories
//   ovf_clr, ovf_set  : clear the sticky flag / set it if the current sum saturates
//   sat_value         : accumulator clamped to DATA_W bits
//   overflow          : sticky saturation flag
module mac_sat #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              acc_en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              ovf_clr,
    input  logic              ovf_set,
    output logic [DATA_W-1:0] sat_value,
    output logic              overflow
);

    localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W - DATA_W){1'b0}}, {DATA_W{1'b1}}};

    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                ovf_q, ovf_d;
    logic [2*DATA_W-1:0] prod;
    logic                saturated;

    assign prod      = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    assign saturated = (acc_q > SAT_MAX);
    assign sat_value = saturated ? {DATA_W{1'b1}} : acc_q[DATA_W-1:0];
    assign overflow  = ovf_q;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (acc_en) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end else if (ovf_set && saturated) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: rtl/matmul_engine.sv
// rtl/matmul_engine.sv - sequencer computing R = A*B from on-chip memories with saturation
//   clk, rst                 : clock, asynchronous active-high reset
//   start                    : run request, sampled only while idle
//   busy, done, overflow     : run in progress, end-of-run pulse, sticky saturation flag
//   a_rd/a_addr/a_data       : A memory read port (data one cycle after strobe)
//   b_rd/b_addr/b_data       : B memory read port (data one cycle after strobe)
//   r_wr/r_addr/r_wdata      : R memory write port
module matmul_engine
    import matmul_pkg::*;
#(
    parameter int ROWS   = 2,
    parameter int INNER  = 2,
    parameter int COLS   = 2,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              a_rd,
    output logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              b_rd,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              r_wr,
    output logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_wdata
);

    localparam int IW    = (ROWS  > 1) ? $clog2(ROWS)  : 1;
    localparam int JW    = (COLS  > 1) ? $clog2(COLS)  : 1;
    localparam int KW    = (INNER > 1) ? $clog2(INNER) : 1;
    localparam int ACC_W = acc_width(DATA_W, INNER);

    localparam logic [IW-1:0] I_MAX = IW'(ROWS - 1);
    localparam logic [JW-1:0] J_MAX = JW'(COLS - 1);
    localparam logic [KW-1:0] K_MAX = KW'(INNER - 1);

    state_e            state_q, state_d;
    logic [IW-1:0]     i_q, i_d;
    logic [JW-1:0]     j_q, j_d;
    logic [KW-1:0]     k_q, k_d;
    logic [ADDR_W-1:0] a_addr_q, a_addr_d;
    logic [ADDR_W-1:0] b_addr_q, b_addr_d;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d;
    logic [DATA_W-1:0] r_wdata_q, r_wdata_d;

    logic [ADDR_W-1:0] a_addr_cur, b_addr_cur, r_addr_cur;
    logic [DATA_W-1:0] sat_value;
    logic              start_accept;
    logic              acc_clr, acc_en, ovf_clr, ovf_set;

    assign start_accept = (state_q == S_IDLE) && start;

    assign a_addr_cur = ADDR_W'(32'(i_q) * 32'(INNER) + 32'(k_q));
    assign b_addr_cur = ADDR_W'(32'(k_q) * 32'(COLS)  + 32'(j_q));
    assign r_addr_cur = ADDR_W'(32'(i_q) * 32'(COLS)  + 32'(j_q));

    // Address/data outputs show the live value only alongside their strobe
    // and otherwise replay the last value driven.
    assign a_addr    = a_rd ? a_addr_cur : a_addr_q;
    assign b_addr    = b_rd ? b_addr_cur : b_addr_q;
    assign r_addr    = r_wr ? r_addr_cur : r_addr_q;
    assign r_wdata   = r_wr ? sat_value  : r_wdata_q;
    assign a_addr_d  = a_addr;
    assign b_addr_d  = b_addr;
    assign r_addr_d  = r_addr;
    assign r_wdata_d = r_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            a_addr_q  <= '0;
            b_addr_q  <= '0;
            r_addr_q  <= '0;
            r_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            a_addr_q  <= a_addr_d;
            b_addr_q  <= b_addr_d;
            r_addr_q  <= r_addr_d;
            r_wdata_q <= r_wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: state_d = S_MAC;
            S_MAC:   state_d = (k_q == K_MAX) ? S_WRITE : S_FETCH;
            S_WRITE: state_d = ((i_q == I_MAX) && (j_q == J_MAX)) ? S_DONE : S_FETCH;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Index counters walk R in row-major order; k restarts for every element.
    always_comb begin
        i_d = i_q;
        j_d = j_q;
        k_d = k_q;
        if (start_accept) begin
            i_d = '0;
            j_d = '0;
            k_d = '0;
        end else if ((state_q == S_MAC) && (k_q != K_MAX)) begin
            k_d = k_q + KW'(1);
        end else if (state_q == S_WRITE) begin
            k_d = '0;
            if (j_q == J_MAX) begin
                j_d = '0;
                i_d = (i_q == I_MAX) ? '0 : i_q + IW'(1);
            end else begin
                j_d = j_q + JW'(1);
            end
        end
    end

    always_comb begin
        a_rd    = 1'b0;
        b_rd    = 1'b0;
        r_wr    = 1'b0;
        done    = 1'b0;
        acc_en  = 1'b0;
        ovf_set = 1'b0;
        busy    = (state_q != S_IDLE);
        acc_clr = start_accept;
        ovf_clr = start_accept;
        case (state_q)
            S_FETCH: begin
                a_rd = 1'b1;
                b_rd = 1'b1;
            end
            S_MAC:   acc_en = 1'b1;
            S_WRITE: begin
                r_wr    = 1'b1;
                ovf_set = 1'b1;
                acc_clr = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    mac_sat #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac_sat (
        .clk       (clk),
        .rst       (rst),
        .clr       (acc_clr),
        .acc_en    (acc_en),
        .a         (a_data),
        .b         (b_data),
        .ovf_clr   (ovf_clr),
        .ovf_set   (ovf_set),
        .sat_value (sat_value),
        .overflow  (overflow)
    );

endmodule

// File: tb/tb_matmul_engine.sv
// tb/tb_matmul_engine.sv - self-checking bench for matmul_engine
module tb_matmul_engine;

    localparam int ROWS     = 2;
    localparam int INNER    = 2;
    localparam int COLS     = 2;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 6;
    localparam int ELEM_CYC = 2 * INNER + 1;
    localparam int RUN_CYC  = ROWS * COLS * ELEM_CYC;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              busy, done, overflow;
    logic              a_rd, b_rd, r_wr;
    logic [ADDR_W-1:0] a_addr, b_addr, r_addr;
    logic [DATA_W-1:0] a_data = '0;
    logic [DATA_W-1:0] b_data = '0;
    logic [DATA_W-1:0] r_wdata;

    always #5 clk = ~clk;

    matmul_engine #(
        .ROWS(ROWS), .INNER(INNER), .COLS(COLS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .overflow(overflow),
        .a_rd(a_rd), .a_addr(a_addr), .a_data(a_data),
        .b_rd(b_rd), .b_addr(b_addr), .b_data(b_data),
        .r_wr(r_wr), .r_addr(r_addr), .r_wdata(r_wdata)
    );

    logic [DATA_W-1:0] mem_a [64];
    logic [DATA_W-1:0] mem_b [64];
    logic [DATA_W-1:0] mem_r [64];

    always @(posedge clk) begin
        if (a_rd) a_data <= mem_a[a_addr];
        if (b_rd) b_data <= mem_b[b_addr];
        if (r_wr) mem_r[r_addr] <= r_wdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    typedef struct {
        int addr;
        int data;
        int rel;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_a[$];
    int  exp_b[$];
    int  exp_frel[$];
    bit  exp_ovf;

    // Reference: plain nested-loop matrix product with clamping, plus the
    // cycle each access must land on counted from the accepting edge.
    task automatic build_model();
        int e;
        int sum;
        exp_wr.delete();
        exp_a.delete();
        exp_b.delete();
        exp_frel.delete();
        exp_ovf = 1'b0;
        e = 0;
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                sum = 0;
                for (int k = 0; k < INNER; k++) begin
                    sum += int'(mem_a[i*INNER+k]) * int'(mem_b[k*COLS+j]);
                    exp_a.push_back(i * INNER + k);
                    exp_b.push_back(k * COLS + j);
                    exp_frel.push_back(e * ELEM_CYC + 2 * k + 1);
                end
                if (sum > 255) begin
                    sum = 255;
                    exp_ovf = 1'b1;
                end
                exp_wr.push_back('{i * COLS + j, sum, (e + 1) * ELEM_CYC});
                e++;
            end
        end
    endtask

    bit armed = 1'b0;
    int t0 = 0;
    int a_cnt, b_cnt, wr_cnt, done_cnt;

    always @(negedge clk) begin
        int  rel;
        wr_t w;
        if (armed) begin
            rel = cyc - t0 + 1;
            if (rel >= 1 && rel <= RUN_CYC + 1) check("busy_in_run", busy, 1);
            if (a_rd) begin
                if (a_cnt < exp_a.size()) begin
                    check("a_addr", a_addr, exp_a[a_cnt]);
                    check("a_rd_cycle", rel, exp_frel[a_cnt]);
                end else begin
                    check("a_rd_extra", a_cnt, exp_a.size() - 1);
                end
                a_cnt++;
            end
            if (b_rd) begin
                if (b_cnt < exp_b.size()) begin
                    check("b_addr", b_addr, exp_b[b_cnt]);
                    check("b_rd_cycle", rel, exp_frel[b_cnt]);
                end else begin
                    check("b_rd_extra", b_cnt, exp_b.size() - 1);
                end
                b_cnt++;
            end
            if (r_wr) begin
                wr_cnt++;
                if (exp_wr.size() == 0) begin
                    check("r_wr_extra", exp_wr.size(), 1);
                end else begin
                    w = exp_wr.pop_front();
                    check("r_addr", r_addr, w.addr);
                    check("r_wdata", r_wdata, w.data);
                    check("r_wr_cycle", rel, w.rel);
                end
            end
            if (done) begin
                done_cnt++;
                check("done_cycle", rel, RUN_CYC + 1);
                check("done_pending_writes", exp_wr.size(), 0);
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_strobes"}, {a_rd, b_rd, r_wr}, 0);
        check({tag, "_addrs"}, {a_addr, b_addr, r_addr}, 0);
        check({tag, "_r_wdata"}, r_wdata, 0);
    endtask

    task automatic load(input int a0, input int a1, input int a2, input int a3,
                        input int b0, input int b1, input int b2, input int b3);
        mem_a[0] = 8'(a0); mem_a[1] = 8'(a1); mem_a[2] = 8'(a2); mem_a[3] = 8'(a3);
        mem_b[0] = 8'(b0); mem_b[1] = 8'(b1); mem_b[2] = 8'(b2); mem_b[3] = 8'(b3);
        for (int n = 0; n < 4; n++) mem_r[n] = 8'hAA;
    endtask

    task automatic check_r(input string tag, input int r0, input int r1, input int r2, input int r3);
        check({tag, "_r0"}, mem_r[0], r0);
        check({tag, "_r1"}, mem_r[1], r1);
        check({tag, "_r2"}, mem_r[2], r2);
        check({tag, "_r3"}, mem_r[3], r3);
    endtask

    // One run: start pulse, optional start toggling while busy, optional
    // reset at cycle abort_at. Bounded to a fixed cycle count.
    task automatic do_run(input bit toggle, input int abort_at);
        build_model();
        a_cnt = 0;
        b_cnt = 0;
        wr_cnt = 0;
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        t0 = cyc + 1;
        armed = 1'b1;
        for (int n = 1; n <= RUN_CYC + 4; n++) begin
            @(negedge clk);
            if (n == 1) check("overflow_cleared_on_start", overflow, 0);
            if (toggle && n >= 3 && n <= 15) start = ~start;
            else start = 1'b0;
            if (n == abort_at) begin
                armed = 1'b0;
                rst = 1'b1;
                #1;
                check_outputs_zero("abort");
                check("abort_no_done", done_cnt, 0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
        end
        armed = 1'b0;
        check("done_pulses", done_cnt, 1);
        check("r_wr_pulses", wr_cnt, ROWS * COLS);
        check("a_rd_pulses", a_cnt, ROWS * COLS * INNER);
        check("b_rd_pulses", b_cnt, ROWS * COLS * INNER);
        check("overflow_after_run", overflow, exp_ovf);
        check("busy_after_run", busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        load(1, 0, 0, 1, 5, 6, 7, 8);
        do_run(1'b0, 0);
        check_r("identity", 5, 6, 7, 8);
        check("identity_overflow", overflow, 0);

        load(1, 2, 3, 4, 5, 6, 7, 8);
        do_run(1'b1, 0);
        check_r("general", 19, 22, 43, 50);

        load(255, 255, 255, 255, 255, 255, 255, 255);
        do_run(1'b0, 0);
        check_r("saturate", 255, 255, 255, 255);
        check("saturate_overflow", overflow, 1);

        load(1, 0, 0, 1, 5, 6, 7, 8);
        do_run(1'b0, 0);
        check_r("after_sat", 5, 6, 7, 8);

        load(1, 2, 3, 4, 5, 6, 7, 8);
        do_run(1'b0, 8);
        do_run(1'b0, 0);
        check_r("after_abort", 19, 22, 43, 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
